// File: rtl/standoff_round_ctrl.sv
// Standoff round sequencer: countdown timer, choice capture/validation, hit resolution, lives/bullets, winner.
// Latency: start->COUNT 1 cycle; round = COUNT_SECS*TICKS_PER_SEC+3 cycles; no backpressure (pause only freezes countdown).
module standoff_round_ctrl #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int COUNT_SECS    = 5,
    parameter int MAX_LIVES     = 3,
    parameter int MAX_BULLETS   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [2:0] p1_choice,
    input  logic [2:0] p2_choice,
    output logic [2:0] state,
    output logic [6:0] countdown,
    output logic       round_tick,
    output logic [2:0] p1_vchoice,
    output logic [2:0] p2_vchoice,
    output logic [1:0] p1_bullets,
    output logic [1:0] p2_bullets,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic       game_over,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COUNT   = 3'd1,
        S_CAPTURE = 3'd2,
        S_RESOLVE = 3'd3,
        S_UPDATE  = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    localparam int          PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [2:0]  SECS0   = 3'(COUNT_SECS);
    localparam logic [1:0]  LIVES0  = 2'(MAX_LIVES);
    localparam logic [1:0]  BMAX    = 2'(MAX_BULLETS);
    localparam logic [2:0]  C_SHOOT  = 3'b001;
    localparam logic [2:0]  C_RELOAD = 3'b010;
    localparam logic [2:0]  C_DUCK   = 3'b100;

    state_t        r_state, w_next;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_sec;
    logic [2:0]    r_c1, r_c2, r_v1, r_v2;
    logic [1:0]    r_b1, r_b2, r_l1, r_l2;
    logic          r_tick;
    logic [1:0]    r_winner;

    logic          w_wrap, w_start, w_hit1, w_hit2, w_over;
    logic [1:0]    w_b1_nxt, w_b2_nxt, w_l1_nxt, w_l2_nxt;

    function automatic logic [2:0] legal(input logic [2:0] c);
        return (c == C_SHOOT || c == C_RELOAD || c == C_DUCK) ? c : 3'b000;
    endfunction

    function automatic logic [1:0] bullets_after(input logic [2:0] v, input logic [1:0] b);
        logic [1:0] res;
        res = b;
        if (v == C_SHOOT && b != 2'd0)
            res = b - 2'd1;
        else if (v == C_RELOAD && b != BMAX)
            res = b + 2'd1;
        return res;
    endfunction

    assign w_wrap  = (r_state == S_COUNT) && !pause && (r_presc == P_LAST);
    assign w_start = start && (r_state == S_IDLE || r_state == S_OVER);

    always_comb begin
        w_b1_nxt = bullets_after(r_v1, r_b1);
        w_b2_nxt = bullets_after(r_v2, r_b2);
        // A player is hit when the opponent fires and they did not duck.
        w_hit1   = (r_v2 == C_SHOOT) && (r_v1 != C_DUCK) && (r_l1 != 2'd0);
        w_hit2   = (r_v1 == C_SHOOT) && (r_v2 != C_DUCK) && (r_l2 != 2'd0);
        w_l1_nxt = r_l1 - {1'b0, w_hit1};
        w_l2_nxt = r_l2 - {1'b0, w_hit2};
        w_over   = (w_l1_nxt == 2'd0) || (w_l2_nxt == 2'd0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (start) w_next = S_COUNT;
            S_COUNT:        if (w_wrap && r_sec == 3'd1) w_next = S_CAPTURE;
            S_CAPTURE:      w_next = S_RESOLVE;
            S_RESOLVE:      w_next = S_UPDATE;
            S_UPDATE:       w_next = w_over ? S_OVER : S_COUNT;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_sec    <= 3'd0;
            r_c1     <= 3'd0;
            r_c2     <= 3'd0;
            r_v1     <= 3'd0;
            r_v2     <= 3'd0;
            r_b1     <= 2'd0;
            r_b2     <= 2'd0;
            r_l1     <= LIVES0;
            r_l2     <= LIVES0;
            r_tick   <= 1'b0;
            r_winner <= 2'd0;
        end else begin
            r_tick <= (r_state == S_UPDATE);

            if (w_next == S_COUNT && r_state != S_COUNT) begin
                r_presc <= '0;
                r_sec   <= SECS0;
            end else if (r_state == S_COUNT && !pause) begin
                if (r_presc == P_LAST) begin
                    r_presc <= '0;
                    if (r_sec != 3'd0) r_sec <= r_sec - 3'd1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (w_start) begin
                r_l1     <= LIVES0;
                r_l2     <= LIVES0;
                r_b1     <= 2'd0;
                r_b2     <= 2'd0;
                r_v1     <= 3'd0;
                r_v2     <= 3'd0;
                r_winner <= 2'd0;
            end

            if (r_state == S_CAPTURE) begin
                r_c1 <= legal(p1_choice);
                r_c2 <= legal(p2_choice);
            end

            // An empty gun cannot fire; a full reload is kept but changes nothing.
            if (r_state == S_RESOLVE) begin
                r_v1 <= (r_c1 == C_SHOOT && r_b1 == 2'd0) ? 3'd0 : r_c1;
                r_v2 <= (r_c2 == C_SHOOT && r_b2 == 2'd0) ? 3'd0 : r_c2;
            end

            if (r_state == S_UPDATE) begin
                r_b1 <= w_b1_nxt;
                r_b2 <= w_b2_nxt;
                r_l1 <= w_l1_nxt;
                r_l2 <= w_l2_nxt;
                if (w_over) r_winner <= {w_l1_nxt == 2'd0, w_l2_nxt == 2'd0};
            end
        end
    end

    assign state      = r_state;
    assign countdown  = (r_state == S_COUNT) ? ~(7'h7f << r_sec) : 7'd0;
    assign round_tick = r_tick;
    assign p1_vchoice = r_v1;
    assign p2_vchoice = r_v2;
    assign p1_bullets = r_b1;
    assign p2_bullets = r_b2;
    assign p1_lives   = r_l1;
    assign p2_lives   = r_l2;
    assign game_over  = (r_state == S_OVER);
    assign winner     = r_winner;
endmodule
